// File: rtl/milestone_pkg.sv
// rtl/milestone_pkg.sv - shared types and bus widths for the milestone sequencer
package milestone_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int MULT_W      = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_bus_mux.sv
// rtl/seq_bus_mux.sv - routes the owning stage's SRAM and multiplier slices to the shared buses
module seq_bus_mux
    import milestone_pkg::*;
#(
    parameter int N_STAGES = 3,
    parameter int N_MULT   = 3,
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int OP_W     = milestone_pkg::MULT_W,
    parameter int SEL_W    = 2
) (
    input  logic                           owned_i,
    input  logic [SEL_W-1:0]               sel_i,
    input  logic [ADDR_W-1:0]              idle_addr_i,
    input  logic [N_STAGES*ADDR_W-1:0]     stg_addr_i,
    input  logic [N_STAGES*DATA_W-1:0]     stg_wdata_i,
    input  logic [N_STAGES-1:0]            stg_we_n_i,
    input  logic [N_STAGES*N_MULT*OP_W-1:0] stg_m1_i,
    input  logic [N_STAGES*N_MULT*OP_W-1:0] stg_m2_i,
    output logic [ADDR_W-1:0]              addr_o,
    output logic [DATA_W-1:0]              wdata_o,
    output logic                           we_n_o,
    output logic [N_MULT*OP_W-1:0]         m1_o,
    output logic [N_MULT*OP_W-1:0]         m2_o
);

    always_comb begin
        addr_o  = idle_addr_i;
        wdata_o = '0;
        we_n_o  = 1'b1;
        m1_o    = '0;
        m2_o    = '0;
        if (owned_i) begin
            addr_o  = stg_addr_i[int'(sel_i)*ADDR_W +: ADDR_W];
            wdata_o = stg_wdata_i[int'(sel_i)*DATA_W +: DATA_W];
            we_n_o  = stg_we_n_i[sel_i];
            for (int m = 0; m < N_MULT; m++) begin
                m1_o[m*OP_W +: OP_W] = stg_m1_i[(int'(sel_i)*N_MULT + m)*OP_W +: OP_W];
                m2_o[m*OP_W +: OP_W] = stg_m2_i[(int'(sel_i)*N_MULT + m)*OP_W +: OP_W];
            end
        end
    end

endmodule

// File: rtl/milestone_seq_arbiter.sv
// rtl/milestone_seq_arbiter.sv - milestone sequencer, watchdog and shared bus owner; STAGE_CYCLE_COUNT_EN adds stage_cycles
module milestone_seq_arbiter
    import milestone_pkg::*;
#(
    parameter int N_STAGES       = 3,
    parameter int N_MULT         = 3,
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int MULT_W         = milestone_pkg::MULT_W,
    parameter int TIMEOUT_CYCLES = 33554432,
    localparam int SW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                             CLOCK_50_I,
    input  logic                             resetn,
    input  logic                             go,
    input  logic [N_STAGES-1:0]              stage_mask,
    input  logic [ADDR_W-1:0]                idle_sram_address,
    output logic [N_STAGES-1:0]              stg_start,
    input  logic [N_STAGES-1:0]              stg_done,
    input  logic [N_STAGES*ADDR_W-1:0]       stg_sram_address,
    input  logic [N_STAGES*DATA_W-1:0]       stg_sram_write_data,
    input  logic [N_STAGES-1:0]              stg_sram_we_n,
    input  logic [N_STAGES*N_MULT*MULT_W-1:0] stg_mult_in1,
    input  logic [N_STAGES*N_MULT*MULT_W-1:0] stg_mult_in2,
    output logic [ADDR_W-1:0]                SRAM_address,
    output logic [DATA_W-1:0]                SRAM_write_data,
    output logic                             SRAM_we_n,
    output logic [N_MULT*MULT_W-1:0]         mult_in1,
    output logic [N_MULT*MULT_W-1:0]         mult_in2,
    output logic                             busy,
    output logic [SW-1:0]                    active_stage,
    output logic                             seq_done,
`ifdef STAGE_CYCLE_COUNT_EN
    output logic [N_STAGES*32-1:0]           stage_cycles,
`endif
    output logic                             err_timeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    seq_state_t           state_q, state_d;
    logic [N_STAGES-1:0]  mask_q, mask_d;
    logic [SW-1:0]        active_q, active_d;
    logic                 err_q, err_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic                 found_first, found_next;
    logic [SW-1:0]        first_idx, next_idx;
    logic                 wd_expired;

    // Scan downwards so the last hit is the lowest qualifying index.
    always_comb begin
        found_first = 1'b0;
        first_idx   = '0;
        found_next  = 1'b0;
        next_idx    = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (stage_mask[i]) begin
                found_first = 1'b1;
                first_idx   = SW'(i);
            end
            if (mask_q[i] && (i > int'(active_q))) begin
                found_next = 1'b1;
                next_idx   = SW'(i);
            end
        end
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        active_d = active_q;
        err_d    = err_q;
        wd_d     = wd_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    mask_d = stage_mask;
                    err_d  = 1'b0;
                    if (found_first) begin
                        state_d  = S_RUN;
                        active_d = first_idx;
                        wd_d     = '0;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RUN: begin
                if (wd_q != '1) wd_d = wd_q + 1'b1;
                if (stg_done[active_q]) begin
                    state_d = S_GAP;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_GAP: begin
                if (found_next) begin
                    state_d  = S_RUN;
                    active_d = next_idx;
                    wd_d     = '0;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            active_q <= active_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        stg_start = '0;
        if (state_q == S_RUN) stg_start[active_q] = 1'b1;
    end

    assign busy         = (state_q != S_IDLE);
    assign seq_done     = (state_q == S_FINISH);
    assign err_timeout  = err_q;
    assign active_stage = active_q;

    seq_bus_mux #(
        .N_STAGES (N_STAGES),
        .N_MULT   (N_MULT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .OP_W     (MULT_W),
        .SEL_W    (SW)
    ) u_bus_mux (
        .owned_i     (state_q == S_RUN),
        .sel_i       (active_q),
        .idle_addr_i (idle_sram_address),
        .stg_addr_i  (stg_sram_address),
        .stg_wdata_i (stg_sram_write_data),
        .stg_we_n_i  (stg_sram_we_n),
        .stg_m1_i    (stg_mult_in1),
        .stg_m2_i    (stg_mult_in2),
        .addr_o      (SRAM_address),
        .wdata_o     (SRAM_write_data),
        .we_n_o      (SRAM_we_n),
        .m1_o        (mult_in1),
        .m2_o        (mult_in2)
    );

`ifdef STAGE_CYCLE_COUNT_EN
    // Stages run at most once per sequence, so clearing every counter on go covers RUN entry too.
    logic [N_STAGES-1:0][31:0] cyc_q;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            cyc_q <= '0;
        end else if (state_q == S_IDLE && go) begin
            cyc_q <= '0;
        end else if (state_q == S_RUN && cyc_q[active_q] != 32'hFFFF_FFFF) begin
            cyc_q[active_q] <= cyc_q[active_q] + 32'd1;
        end
    end

    assign stage_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_milestone_seq_arbiter.sv
// tb/tb_milestone_seq_arbiter.sv - self-checking bench for milestone_seq_arbiter
module tb_milestone_seq_arbiter;

    localparam int NS = 3;
    localparam int NM = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int MW = 32;
    localparam int T  = 24;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    go;
    logic [NS-1:0]           stage_mask;
    logic [AW-1:0]           idle_sram_address;
    logic [NS-1:0]           stg_start;
    logic [NS-1:0]           stg_done;
    logic [NS*AW-1:0]        stg_sram_address;
    logic [NS*DW-1:0]        stg_sram_write_data;
    logic [NS-1:0]           stg_sram_we_n;
    logic [NS*NM*MW-1:0]     stg_mult_in1;
    logic [NS*NM*MW-1:0]     stg_mult_in2;
    logic [AW-1:0]           SRAM_address;
    logic [DW-1:0]           SRAM_write_data;
    logic                    SRAM_we_n;
    logic [NM*MW-1:0]        mult_in1;
    logic [NM*MW-1:0]        mult_in2;
    logic                    busy;
    logic [1:0]              active_stage;
    logic                    seq_done;
    logic                    err_timeout;

    always #10 clk = ~clk;

    milestone_seq_arbiter #(
        .N_STAGES(NS), .N_MULT(NM), .ADDR_W(AW), .DATA_W(DW), .MULT_W(MW), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK_50_I          (clk),
        .resetn              (resetn),
        .go                  (go),
        .stage_mask          (stage_mask),
        .idle_sram_address   (idle_sram_address),
        .stg_start           (stg_start),
        .stg_done            (stg_done),
        .stg_sram_address    (stg_sram_address),
        .stg_sram_write_data (stg_sram_write_data),
        .stg_sram_we_n       (stg_sram_we_n),
        .stg_mult_in1        (stg_mult_in1),
        .stg_mult_in2        (stg_mult_in2),
        .SRAM_address        (SRAM_address),
        .SRAM_write_data     (SRAM_write_data),
        .SRAM_we_n           (SRAM_we_n),
        .mult_in1            (mult_in1),
        .mult_in2            (mult_in2),
        .busy                (busy),
        .active_stage        (active_stage),
        .seq_done            (seq_done),
        .err_timeout         (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] start;
        logic       busy;
        logic       done;
        logic       err;
        int         owner;
    } cyc_t;

    cyc_t          exp_q[$];
    int            dur[NS];
    logic [AW-1:0] s_addr[NS];
    logic [DW-1:0] s_data[NS];
    logic          s_we[NS];
    logic [MW-1:0] s_m1[NS][NM];
    logic [MW-1:0] s_m2[NS][NM];

    task automatic randomize_bus(input bit fix0);
        idle_sram_address = AW'($urandom);
        for (int s = 0; s < NS; s++) begin
            s_addr[s] = AW'($urandom);
            s_data[s] = DW'($urandom);
            s_we[s]   = 1'($urandom);
            for (int m = 0; m < NM; m++) begin
                s_m1[s][m] = $urandom;
                s_m2[s][m] = $urandom;
            end
        end
        if (fix0) begin
            s_addr[0] = 18'h00100;
            s_data[0] = 16'hBEEF;
            s_we[0]   = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            stg_sram_address[s*AW +: AW]    = s_addr[s];
            stg_sram_write_data[s*DW +: DW] = s_data[s];
            stg_sram_we_n[s]                = s_we[s];
            for (int m = 0; m < NM; m++) begin
                stg_mult_in1[(s*NM+m)*MW +: MW] = s_m1[s][m];
                stg_mult_in2[(s*NM+m)*MW +: MW] = s_m2[s][m];
            end
        end
    endtask

    // Expected trace: each enabled stage owns the bus for its runtime (or T cycles on abort),
    // one ownerless gap follows each completed stage, and a single finish cycle closes the run.
    task automatic run_seq(input string name, input logic [2:0] mask, input bit fix0, input bit noise);
        cyc_t          e;
        bit            aborted;
        int            n;
        int            cnt[NS];
        logic [2:0]    d;
        logic [AW+DW:0] bus_exp;
        logic [NM*MW-1:0] m1_exp, m2_exp;
        exp_q.delete();
        aborted = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (mask[s] && !aborted) begin
                n = (dur[s] == 0 || dur[s] > T) ? T : dur[s];
                for (int k = 0; k < n; k++) begin
                    e = '{start: 3'b001 << s, busy: 1'b1, done: 1'b0, err: 1'b0, owner: s};
                    exp_q.push_back(e);
                end
                if (dur[s] == 0 || dur[s] > T) begin
                    aborted = 1'b1;
                end else begin
                    e = '{start: 3'b000, busy: 1'b1, done: 1'b0, err: 1'b0, owner: -1};
                    exp_q.push_back(e);
                end
            end
        end
        e = '{start: 3'b000, busy: 1'b1, done: 1'b1, err: aborted, owner: -1};
        exp_q.push_back(e);

        for (int s = 0; s < NS; s++) cnt[s] = 0;
        @(negedge clk);
        go = 1'b1;
        stage_mask = mask;
        stg_done = '0;
        randomize_bus(fix0);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            go = noise ? 1'($urandom) : 1'b0;
            if (noise) stage_mask = 3'($urandom);
            for (int s = 0; s < NS; s++) begin
                cnt[s] = stg_start[s] ? cnt[s] + 1 : 0;
                d[s] = stg_start[s] && (cnt[s] == dur[s]);
                if (!stg_start[s] && noise) d[s] = 1'($urandom);
            end
            stg_done = d;
            randomize_bus(fix0);
            #1;
            e = exp_q[k];
            checks++;
            if ({stg_start, busy, seq_done, err_timeout} !== {e.start, e.busy, e.done, e.err}) begin
                errors++;
                $display("FAIL %s ctrl cyc %0d start/busy/done/err got %b %b %b %b exp %b %b %b %b",
                         name, k, stg_start, busy, seq_done, err_timeout, e.start, e.busy, e.done, e.err);
            end
            if (e.owner >= 0) begin
                checks++;
                if (active_stage !== 2'(e.owner)) begin
                    errors++;
                    $display("FAIL %s active cyc %0d got %0d exp %0d", name, k, active_stage, e.owner);
                end
                bus_exp = {s_addr[e.owner], s_data[e.owner], s_we[e.owner]};
                for (int m = 0; m < NM; m++) begin
                    m1_exp[m*MW +: MW] = s_m1[e.owner][m];
                    m2_exp[m*MW +: MW] = s_m2[e.owner][m];
                end
            end else begin
                bus_exp = {idle_sram_address, 16'h0000, 1'b1};
                m1_exp = '0;
                m2_exp = '0;
            end
            checks++;
            if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== bus_exp) begin
                errors++;
                $display("FAIL %s sram cyc %0d got %h exp %h", name, k,
                         {SRAM_address, SRAM_write_data, SRAM_we_n}, bus_exp);
            end
            checks++;
            if ({mult_in1, mult_in2} !== {m1_exp, m2_exp}) begin
                errors++;
                $display("FAIL %s mult cyc %0d got %h exp %h", name, k, {mult_in1, mult_in2}, {m1_exp, m2_exp});
            end
        end
        @(negedge clk);
        go = 1'b0;
        stg_done = '0;
        #1;
        checks++;
        if ({stg_start, busy, seq_done, err_timeout} !== {3'b000, 1'b0, 1'b0, aborted}) begin
            errors++;
            $display("FAIL %s after start/busy/done/err got %b %b %b %b exp 000 0 0 %b",
                     name, stg_start, busy, seq_done, err_timeout, aborted);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        go = 1'b0;
        stage_mask = '0;
        stg_done = '0;
        randomize_bus(1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({stg_start, busy, seq_done, err_timeout, active_stage} !== 8'b0) begin
            errors++;
            $display("FAIL reset state got %b %b %b %b %0d exp all zero",
                     stg_start, busy, seq_done, err_timeout, active_stage);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_three_stages();
        dur = '{10, 20, 5};
        run_seq("three_stages", 3'b111, 1'b0, 1'b0);
    endtask

    task automatic test_mask_101_write();
        dur = '{8, 3, 6};
        run_seq("mask101", 3'b101, 1'b1, 1'b0);
    endtask

    task automatic test_empty_mask();
        dur = '{4, 4, 4};
        run_seq("empty_mask", 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        dur = '{5, 0, 7};
        run_seq("timeout", 3'b111, 1'b0, 1'b0);
        dur = '{4, 4, 4};
        run_seq("err_clear", 3'b001, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        dur = '{6, 12, 4};
        run_seq("ignored", 3'b111, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            for (int s = 0; s < NS; s++)
                dur[s] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 30));
            run_seq("random", 3'($urandom), 1'b0, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        int  c0;
        bit  seen;
        c0 = 0;
        seen = 1'b0;
        @(negedge clk);
        go = 1'b1;
        stage_mask = 3'b111;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            go = 1'b0;
            c0 = stg_start[0] ? c0 + 1 : 0;
            stg_done = {2'b00, stg_start[0] && c0 == 3};
            #1;
            if (stg_start == 3'b010) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid stage1 start got %b exp 010 within 40 cycles", stg_start);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        idle_sram_address = 18'h2A5A5;
        #1;
        checks++;
        if ({stg_start, busy, seq_done, SRAM_address} !== {3'b000, 1'b0, 1'b0, 18'h2A5A5}) begin
            errors++;
            $display("FAIL reset_mid start/busy/done/addr got %b %b %b %h exp 000 0 0 2a5a5",
                     stg_start, busy, seq_done, SRAM_address);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({stg_start, busy, seq_done} !== 5'b0) begin
                errors++;
                $display("FAIL reset_mid quiet cyc %0d got %b %b %b exp 000 0 0", k, stg_start, busy, seq_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_stages();
        test_mask_101_write();
        test_empty_mask();
        test_timeout();
        test_ignored_inputs();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
